posedge_rate_scaler: RTL

// Windowed rate meter that sits directly downstream of posedge_counter. It drives
// the counter's enable to open a programmable gate window, then captures the final

---
 rtl/posedge_rate_scaler.sv | 104 ++++++++++
 1 files changed

// File: rtl/posedge_rate_scaler.sv
// Windowed rate meter: gates a downstream-of posedge_counter enable for a programmable
// number of cycles, captures the final count and presents it on a valid/ack register.
module posedge_rate_scaler #(
  parameter int CNT_W   = 16,
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [TIMER_W-1:0] window_len,
  input  logic [CNT_W-1:0]   cnt_in,
  output logic               cnt_en,
  output logic [CNT_W-1:0]   rate_out,
  output logic               rate_sat,
  output logic               rate_valid,
  input  logic               rate_ack,
  output logic               overrun,
  output logic [15:0]        n_windows
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [TIMER_W-1:0] timer_load;
  logic               latch_now;
  logic               ack_now;

  // A zero length still opens the gate for one cycle.
  assign timer_load = (window_len == '0) ? '0 : window_len - TIMER_W'(1);
  assign latch_now  = (state_reg == LATCH);
  assign ack_now    = rate_ack && rate_valid;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    unique case (state_reg)
      IDLE: begin
        if (enable) state_next = CLEAR;
      end
      CLEAR: begin
        timer_next = timer_load;
        state_next = GATE;
      end
      GATE: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (timer_reg == '0) begin
          state_next = LATCH;
        end else begin
          timer_next = timer_reg - TIMER_W'(1);
        end
      end
      LATCH: begin
        if (enable) begin
          timer_next = timer_load;
          state_next = GATE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      cnt_en    <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      // Registered copy of "next state is GATE" so cnt_en tracks the state register.
      cnt_en    <= (state_next == GATE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_out   <= '0;
      rate_sat   <= 1'b0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
      n_windows  <= '0;
    end else if (latch_now) begin
      rate_out   <= cnt_in;
      rate_sat   <= &cnt_in;
      rate_valid <= 1'b1;
      n_windows  <= n_windows + 16'd1;
      // An ack on the latch cycle consumes the old result, so it is not an overrun.
      if (rate_valid && !rate_ack) overrun <= 1'b1;
    end else begin
      if (ack_now) rate_valid <= 1'b0;
      if (state_reg == CLEAR) overrun <= 1'b0;
    end
  end

endmodule
